// File: rtl/kf6845_video_pkg.sv
// Shared types and field positions for the KF6845 text pixel path.
// Attribute byte layout: [3:0] foreground, [7:4] background, [7] blink when KF6845_BLINK_EN.
package kf6845_video_pkg;

    localparam int unsigned CHAR_WIDTH   = 8;
    localparam int unsigned MA_W         = 14;
    localparam int unsigned RA_W         = 5;
    localparam int unsigned VRAM_W       = 16;
    localparam int unsigned FONT_AW      = 12;
    localparam int unsigned ATTR_W       = 8;
    localparam int unsigned COLOR_W      = 4;
    localparam int unsigned FRAME_W      = 5;

    localparam int unsigned ATTR_FG_LSB  = 0;
    localparam int unsigned ATTR_BG_LSB  = 4;
    localparam int unsigned ATTR_BLINK   = 7;

    typedef logic [COLOR_W-1:0] color_t;

    // Cursor beats glyph; a hidden (blinked-off) glyph bit falls back to background.
    function automatic color_t pixel_color(input logic glyph_bit, input logic hide,
                                           input logic cursor_active,
                                           input color_t fg, input color_t bg);
        color_t c;
        c = bg;
        if (glyph_bit && !hide) c = fg;
        if (cursor_active)      c = fg;
        return c;
    endfunction

endpackage

// File: rtl/kf6845_pixel_shifter.sv
// Per-cell glyph shift register and colour mux; video_color is registered here.
module kf6845_pixel_shifter
    import kf6845_video_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [CHAR_WIDTH-1:0] row,
    input  color_t                fg,
    input  color_t                bg,
    input  logic                  hide,
    input  logic                  cursor_active,
    output color_t                color
);

    // Only the bits not yet shown are kept; bit 7 goes straight to the colour on load.
    logic [CHAR_WIDTH-2:0] pend_q, pend_d;
    color_t                fg_q, fg_d, bg_q, bg_d, color_q, color_d;
    logic                  hide_q, hide_d, cursor_q, cursor_d;

    always_comb begin
        pend_d   = pend_q;
        fg_d     = fg_q;
        bg_d     = bg_q;
        hide_d   = hide_q;
        cursor_d = cursor_q;
        color_d  = color_q;
        if (load) begin
            pend_d   = row[CHAR_WIDTH-2:0];
            fg_d     = fg;
            bg_d     = bg;
            hide_d   = hide;
            cursor_d = cursor_active;
            color_d  = pixel_color(row[CHAR_WIDTH-1], hide, cursor_active, fg, bg);
        end else if (shift) begin
            pend_d  = {pend_q[CHAR_WIDTH-3:0], 1'b0};
            color_d = pixel_color(pend_q[CHAR_WIDTH-2], hide_q, cursor_q, fg_q, bg_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q   <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            hide_q   <= 1'b0;
            cursor_q <= 1'b0;
            color_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            hide_q   <= hide_d;
            cursor_q <= cursor_d;
            color_q  <= color_d;
        end
    end

    assign color = color_q;

endmodule

// File: rtl/kf6845_text_pixel_generator.sv
// Text-mode pixel generator behind the KF6845: paces the CRTC, fetches char/attr and glyph, serializes pixels.
// Optional character blink and cursor blink with KF6845_BLINK_EN.
module kf6845_text_pixel_generator
    import kf6845_video_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pixel_clock_enable,
    output logic                  char_clock_enable,
    input  logic [MA_W-1:0]       crtc_ma,
    input  logic [RA_W-1:0]       crtc_ra,
    input  logic                  crtc_de,
    input  logic                  crtc_cursor,
    input  logic                  crtc_hsync,
    input  logic                  crtc_vsync,
    output logic [MA_W-1:0]       vram_address,
    output logic                  vram_read,
    input  logic [VRAM_W-1:0]     vram_data,
    output logic [FONT_AW-1:0]    font_address,
    output logic                  font_read,
    input  logic [CHAR_WIDTH-1:0] font_data,
    output color_t                video_color,
    output logic                  video_hsync,
    output logic                  video_vsync,
    output logic                  video_de
);

    logic [2:0]            pixel_count_q, pixel_count_d;
    logic                  vram_read_q, vram_read_d, font_read_q, font_read_d;
    logic                  font_pend_q, font_pend_d;
    logic [MA_W-1:0]       ma_a_q, ma_a_d;
    logic [3:0]            ra_a_q, ra_a_d;
    logic                  de_a_q, de_a_d, cur_a_q, cur_a_d, hs_a_q, hs_a_d, vs_a_q, vs_a_d;
    logic [ATTR_W-1:0]     attr_h_q, attr_h_d;
    logic [CHAR_WIDTH-1:0] row_h_q, row_h_d;
    logic                  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    color_t                fg_c, bg_c;
    logic                  hide_c, cursor_active_c;
    logic                  ra_msb_unused;

    assign ra_msb_unused     = crtc_ra[RA_W-1];
    assign char_clock_enable = pixel_clock_enable && (pixel_count_q == 3'd7) && !reset;

`ifdef KF6845_BLINK_EN
    logic [FRAME_W-1:0] frame_q, frame_d;

    always_comb begin
        frame_d = frame_q;
        if (char_clock_enable && crtc_vsync && !vs_a_q) frame_d = frame_q + FRAME_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) frame_q <= '0;
        else       frame_q <= frame_d;
    end

    assign bg_c            = de_a_q ? {1'b0, attr_h_q[ATTR_BG_LSB +: 3]} : '0;
    assign hide_c          = attr_h_q[ATTR_BLINK] && frame_q[4];
    assign cursor_active_c = cur_a_q && !frame_q[3];
`else
    assign bg_c            = de_a_q ? attr_h_q[ATTR_BG_LSB +: COLOR_W] : '0;
    assign hide_c          = 1'b0;
    assign cursor_active_c = cur_a_q;
`endif

    // Blanked cells force both colours to 0 so the shifter needs no DE input.
    assign fg_c = de_a_q ? attr_h_q[ATTR_FG_LSB +: COLOR_W] : '0;

    always_comb begin
        pixel_count_d = pixel_count_q;
        vram_read_d   = char_clock_enable;
        font_read_d   = vram_read_q;
        font_pend_d   = font_read_q;
        ma_a_d        = ma_a_q;
        ra_a_d        = ra_a_q;
        de_a_d        = de_a_q;
        cur_a_d       = cur_a_q;
        hs_a_d        = hs_a_q;
        vs_a_d        = vs_a_q;
        attr_h_d      = attr_h_q;
        row_h_d       = row_h_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        if (pixel_clock_enable) pixel_count_d = pixel_count_q + 3'd1;
        if (font_read_q)        attr_h_d      = vram_data[VRAM_W-1:CHAR_WIDTH];
        if (font_pend_q)        row_h_d       = font_data;
        if (char_clock_enable) begin
            ma_a_d  = crtc_ma;
            ra_a_d  = crtc_ra[3:0];
            de_a_d  = crtc_de;
            cur_a_d = crtc_cursor;
            hs_a_d  = crtc_hsync;
            vs_a_d  = crtc_vsync;
            hsync_d = hs_a_q;
            vsync_d = vs_a_q;
            de_d    = de_a_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_count_q <= '0;
            vram_read_q   <= 1'b0;
            font_read_q   <= 1'b0;
            font_pend_q   <= 1'b0;
            ma_a_q        <= '0;
            ra_a_q        <= '0;
            de_a_q        <= 1'b0;
            cur_a_q       <= 1'b0;
            hs_a_q        <= 1'b0;
            vs_a_q        <= 1'b0;
            attr_h_q      <= '0;
            row_h_q       <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
        end else begin
            pixel_count_q <= pixel_count_d;
            vram_read_q   <= vram_read_d;
            font_read_q   <= font_read_d;
            font_pend_q   <= font_pend_d;
            ma_a_q        <= ma_a_d;
            ra_a_q        <= ra_a_d;
            de_a_q        <= de_a_d;
            cur_a_q       <= cur_a_d;
            hs_a_q        <= hs_a_d;
            vs_a_q        <= vs_a_d;
            attr_h_q      <= attr_h_d;
            row_h_q       <= row_h_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
        end
    end

    kf6845_pixel_shifter u_shifter (
        .clock         (clock),
        .reset         (reset),
        .load          (char_clock_enable),
        .shift         (pixel_clock_enable),
        .row           (row_h_q),
        .fg            (fg_c),
        .bg            (bg_c),
        .hide          (hide_c),
        .cursor_active (cursor_active_c),
        .color         (video_color)
    );

    // Character code is consumed in the same cycle it arrives, so only the attribute is held.
    assign font_address = font_read_q ? {vram_data[CHAR_WIDTH-1:0], ra_a_q} : '0;
    assign vram_address = ma_a_q;
    assign vram_read    = vram_read_q;
    assign font_read    = font_read_q;
    assign video_hsync  = hsync_q;
    assign video_vsync  = vsync_q;
    assign video_de     = de_q;

endmodule
